gate_op_scheduler: RTL and testbench
====================================

// Module: gate_op_scheduler
// PURPOSE
//  Shares one basic-gate evaluation unit (AND/OR/NOT/NAND/NOR/XOR/XNOR/BUF) among
//  NUM_REQ requesters. Round-robin arbitration, one operation in flight at a time,
//  valid/ready handshake on both request and response sides.
//  Sits between the gate-exercise requesters and the shared gate datapath.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8)
//  WIDTH     8   operand/result bit width
//  ID_W      2   requester-id width (must equal clog2(NUM_REQ))
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              synchronous reset, active-low
//  req_valid  in   NUM_REQ        per-requester request valid
//  req_ready  out  NUM_REQ        one-hot accept strobe, comb., from IDLE only
//  req_op     in   NUM_REQ*3      opcode per requester, slice i = [3*i+:3]
//  req_a      in   NUM_REQ*WIDTH  operand A per requester
//  req_b      in   NUM_REQ*WIDTH  operand B per requester (ignored for NOT/BUF)
//  rsp_valid  out  1              result valid
//  rsp_ready  in   1              consumer accepts result
//  rsp_data   out  WIDTH          bitwise gate result
//  rsp_id     out  ID_W           index of requester that owns rsp_data
//  busy       out  1              high in EXEC or RESP
// BEHAVIOUR
//  Opcodes: 0 AND, 1 OR, 2 NOT(a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 BUF(a); all bitwise.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: if any req_valid, winner = first valid at/after rr_ptr (wrapping);
//         req_ready[winner]=1 this cycle; op/a/b/id registered; -> EXEC.
//         No valid: stay, req_ready=0.
//   EXEC: result = gate(op,a,b) registered into rsp_data; -> RESP (1 cycle).
//   RESP: rsp_valid=1; rsp_data/rsp_id held stable until rsp_ready.
//         rsp_valid&rsp_ready: -> IDLE, rr_ptr = winner+1 (wrap NUM_REQ-1 -> 0).
//  Latency: accept cycle T -> rsp_valid first high at T+2. Min throughput 1 op / 3 cycles.
//  req_ready is 0 in EXEC and RESP; requests stay pending (not dropped) meanwhile.
//  Requester that deasserts req_valid before grant is simply skipped.
//  Only the granted requester's ready asserts; simultaneous valids resolved by rr_ptr.
//  Reset (any state, incl. mid-operation): state=IDLE, rr_ptr=0, rsp_valid=0,
//   rsp_data=0, rsp_id=0, busy=0, req_ready=0; in-flight op discarded, no response.
//  rsp_ready while rsp_valid=0: ignored.
// CONFIGURATION
//  GATE_SCHED_STATS_EN defined: adds output grant_cnt [NUM_REQ*16], slice i counts
//   accepts of requester i, 16-bit saturating at 16'hFFFF, cleared by reset.
//  Undefined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  Package gate_sched_pkg: opcode localparams (OP_AND..OP_BUF), FSM state encodings
//   (ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2).
//  Sub-module gate_eval_unit: combinational WIDTH-bit op/a/b -> y; instantiated once
//   inside the scheduler; scheduler owns all sequential state.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles mid-RESP -> rsp_valid=0, busy=0, req_ready=0, next grant to req0.
//  2 Single op: req1 valid, op=1(OR), a=8'h0F, b=8'hF0, rsp_ready=1 -> rsp_data=8'hFF,
//    rsp_id=1, rsp_valid at accept+2.
//  3 Round robin: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; one per 3 cycles.
//  4 Backpressure: rsp_ready=0 for 5 cycles, op=5(XOR) a=8'hAA b=8'hFF -> rsp_data=8'h55 held
//    stable, req_ready all 0 until handshake.
//  5 Opcode sweep: a=8'hC3, b=8'hA5 all 8 ops -> 81,E7,3C,7E,18,66,99,C3.
//  6 STATS_EN build: 3 ops from req2 -> grant_cnt[2]=3, others 0; saturation via forced preload.

Source files
------------

// File: rtl/gate_sched_pkg.sv
// Shared opcode and FSM state definitions for the gate operation scheduler.
package gate_sched_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/gate_eval_unit.sv
// Combinational bitwise gate evaluator; operand b is unused by NOT and BUF.
module gate_eval_unit
    import gate_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_BUF:  y = a;
        endcase
    end

endmodule

// File: rtl/gate_op_scheduler.sv
// Round-robin scheduler sharing one gate evaluation unit among NUM_REQ requesters.
// Optional per-requester accept counters when GATE_SCHED_STATS_EN is defined.
module gate_op_scheduler
    import gate_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*3-1:0]     req_op,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
`ifdef GATE_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]    grant_cnt
`endif
);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   idx;
    logic              any_vld;
    logic              accept;
    logic [2:0]        op_p0;
    logic [WIDTH-1:0]  a_p0;
    logic [WIDTH-1:0]  b_p0;
    logic [WIDTH-1:0]  gate_y;

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
    endfunction

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        any_vld = 1'b0;
        win     = rr_ptr;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_vld && req_valid[idx]) begin
                any_vld = 1'b1;
                win     = idx;
            end
        end
    end

    assign accept = rst_n && (state == ST_IDLE) && any_vld;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win] = 1'b1;
    end

    // Stage p0: operands captured at accept, no reset needed on data.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && any_vld) begin
            op_p0 <= req_op[3*int'(win) +: 3];
            a_p0  <= req_a[WIDTH*int'(win) +: WIDTH];
            b_p0  <= req_b[WIDTH*int'(win) +: WIDTH];
        end
    end

    gate_eval_unit #(.WIDTH(WIDTH)) u_eval (
        .op (op_p0),
        .a  (a_p0),
        .b  (b_p0),
        .y  (gate_y)
    );

    // Stage p1: result registered in EXEC and held through RESP until handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_vld) begin
                        state  <= ST_EXEC;
                        busy   <= 1'b1;
                        rsp_id <= win;
                    end
                end
                ST_EXEC: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= gate_y;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        rr_ptr    <= next_ptr(rsp_id);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef GATE_SCHED_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else if (state == ST_IDLE && any_vld) begin
            grant_cnt[16*int'(win) +: 16] <= sat_inc16(grant_cnt[16*int'(win) +: 16]);
        end
    end
`endif

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Bench for gate_op_scheduler: transaction-level model checked every cycle plus directed literals.
module tb_gate_op_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*3-1:0] req_op;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic [IW-1:0]  rsp_id;
    logic           busy;
`ifdef GATE_SCHED_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gate_op_scheduler #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef GATE_SCHED_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] gate_ref(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return ~a;
            3: return ~(a & b);
            4: return ~(a | b);
            5: return a ^ b;
            6: return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // Transaction model: one op in flight, response due two cycles after accept.
    bit            chk_en = 1'b0;
    int            cyc = 0;
    bit            m_busy = 1'b0;
    int            m_tacc = 0;
    int            m_ptr = 0;
    logic [IW-1:0] m_id = '0;
    logic [W-1:0]  m_res = '0;
`ifdef GATE_SCHED_STATS_EN
    int            m_cnt [N];
`endif

    always @(negedge clk) begin : model
        logic [N-1:0] exp_rr;
        bit           exp_v;
        int           pick;
        cyc++;
        pick = -1;
        for (int k = 0; k < N; k++) begin
            if (pick < 0 && ((req_valid >> ((m_ptr + k) % N)) & N'(1)) != 0)
                pick = (m_ptr + k) % N;
        end
        exp_v  = m_busy && (cyc >= m_tacc + 2);
        exp_rr = '0;
        if (rst_n && !m_busy && pick >= 0) exp_rr = N'(1) << pick;
        if (chk_en) begin
            chk("m_req_ready", 64'(req_ready), 64'(exp_rr));
            chk("m_busy", 64'(busy), 64'(m_busy));
            chk("m_rsp_valid", 64'(rsp_valid), 64'(exp_v));
            if (exp_v) begin
                chk("m_rsp_data", 64'(rsp_data), 64'(m_res));
                chk("m_rsp_id", 64'(rsp_id), 64'(m_id));
            end
`ifdef GATE_SCHED_STATS_EN
            for (int k = 0; k < N; k++)
                chk("m_grant_cnt", 64'(16'(grant_cnt >> (16*k))), 64'(m_cnt[k]));
`endif
        end
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr  = 0;
`ifdef GATE_SCHED_STATS_EN
            for (int k = 0; k < N; k++) m_cnt[k] = 0;
`endif
        end else if (!m_busy) begin
            if (pick >= 0) begin
                m_busy = 1'b1;
                m_tacc = cyc;
                m_id   = IW'(pick);
                m_res  = gate_ref(int'(3'(req_op >> (3*pick))), W'(req_a >> (W*pick)),
                                  W'(req_b >> (W*pick)));
`ifdef GATE_SCHED_STATS_EN
                if (m_cnt[pick] < 16'hFFFF) m_cnt[pick]++;
`endif
            end
        end else if (exp_v && rsp_ready) begin
            m_busy = 1'b0;
            m_ptr  = (int'(m_id) + 1) % N;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op[3*i +: 3] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
        req_valid        = req_valid | (N'(1) << i);
    endtask

    task automatic clr_req(input int i);
        req_valid = req_valid & ~(N'(1) << i);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        if (!rsp_valid) chk("rsp_timeout", 64'(rsp_valid), 64'd1);
    endtask

    // Issue one op to an idle scheduler with rsp_ready=1; checks grant, latency and result.
    task automatic do_op(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input string nm);
        int lat;
        set_req(i, op, a, b);
        @(negedge clk);
        chk({nm, "_ready"}, 64'(req_ready), 64'(N'(1) << i));
        tick();
        clr_req(i);
        wait_rsp(lat);
        chk({nm, "_lat"}, 64'(lat), 64'd2);
        chk({nm, "_data"}, 64'(rsp_data), 64'(exp));
        chk({nm, "_id"}, 64'(rsp_id), 64'(i));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] sweep [8];
        int           lat;
        int           gidx [$];
        int           gcyc [$];
        int           n;
        sweep = '{8'h81, 8'hE7, 8'h3C, 8'h7E, 8'h18, 8'h66, 8'h99, 8'hC3};

        rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("por_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("por_busy", 64'(busy), 64'd0);
        chk("por_req_ready", 64'(req_ready), 64'd0);
        chk("por_rsp_data", 64'(rsp_data), 64'd0);
        tick();
        rst_n = 1'b1;

        // single OR from requester 1
        rsp_ready = 1'b1;
        do_op(1, 3'd1, 8'h0F, 8'hF0, 8'hFF, "single");

        // backpressure: rr_ptr=2, req3 wins over pending req0
        rsp_ready = 1'b0;
        set_req(0, 3'd0, 8'h3C, 8'h0F);
        set_req(3, 3'd5, 8'hAA, 8'hFF);
        @(negedge clk);
        chk("bp_grant3", 64'(req_ready), 64'b1000);
        tick();
        clr_req(3);
        wait_rsp(lat);
        chk("bp_data", 64'(rsp_data), 64'h55);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("bp_hold_data", 64'(rsp_data), 64'h55);
            chk("bp_hold_ready", 64'(req_ready), 64'd0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("bp_pending_grant0", 64'(req_ready), 64'b0001);
        tick();
        clr_req(0);
        wait_rsp(lat);
        chk("bp_and_data", 64'(rsp_data), 64'h0C);
        tick();

        // opcode sweep on requester 0
        for (int op = 0; op < 8; op++)
            do_op(0, 3'(op), 8'hC3, 8'hA5, sweep[op], "sweep");

        // reset while holding a response
        rsp_ready = 1'b0;
        set_req(2, 3'd1, 8'h12, 8'h40);
        @(negedge clk);
        tick();
        clr_req(2);
        set_req(1, 3'd0, 8'hFF, 8'h0F);
        wait_rsp(lat);
        chk("rst_pre_data", 64'(rsp_data), 64'h52);
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        tick();
        tick();

        // round robin with all requesters valid; first grant must be req0
        for (int i = 0; i < N; i++) set_req(i, 3'(i + 1), 8'h5A, 8'h33);
        rsp_ready = 1'b1;
        rst_n     = 1'b1;
        n = 0;
        while (gidx.size() < 5 && n < 40) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < N; i++) begin
                if (((req_ready >> i) & N'(1)) != 0) begin
                    gidx.push_back(i);
                    gcyc.push_back(n);
                end
            end
        end
        chk("rr_count", 64'(gidx.size()), 64'd5);
        if (gidx.size() == 5) begin
            chk("rr_g0", 64'(gidx[0]), 64'd0);
            chk("rr_g1", 64'(gidx[1]), 64'd1);
            chk("rr_g2", 64'(gidx[2]), 64'd2);
            chk("rr_g3", 64'(gidx[3]), 64'd3);
            chk("rr_g4", 64'(gidx[4]), 64'd0);
            for (int k = 1; k < 5; k++)
                chk("rr_spacing", 64'(gcyc[k] - gcyc[k-1]), 64'd3);
        end
        tick();
        req_valid = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 10);
        chk("rr_drain_busy", 64'(busy), 64'd0);

`ifdef GATE_SCHED_STATS_EN
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) do_op(2, 3'd7, 8'(k), 8'h00, 8'(k), "stats_op");
        @(negedge clk);
        chk("stats_cnt", 64'(grant_cnt), 64'h0000_0003_0000_0000);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
